multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 64: datapath width; 32 or 64 only; word-op opcodes (0011011, 0111011) are legal only when XLEN=64.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready before an access-fault trap; range 1..255.
REQ-003 The block SHALL have parameter CAUSE_W, default 4: width of cause output.
REQ-004 The block SHALL have these ports: clk  in  1  clock, rising edge.
REQ-005 The block SHALL have these ports: reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have these ports: instr  in  32  current IR contents; irq  in  1  level interrupt request; mem_ready  in  1  memory access complete.
REQ-007 The block SHALL have these ports: state_o  out  4  current state; mem_req  out  1; mem_we  out  1; mem_size  out  2  (instr[13:12] for load/store, 2'b10 for fetch).
REQ-008 The block SHALL have these ports: ir_load, pc_write, load_a, load_b, load_aluout, load_mdr, reg_write, epc_write, cause_write, alu_word, halted  out  1 each.
REQ-009 The block SHALL have these ports: pc_src  out  2  (00 ALU, 01 ALUOut, 10 trap vector); branch_mode  out  3  (000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu).
REQ-010 The block SHALL have these ports: alu_src_a  out  2  (00 PC, 01 A); alu_src_b  out  2  (00 B, 01 const 4, 10 imm, 11 imm branch); alu_op  out  4  (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra); wb_sel  out  3  (0 ALUOut, 1 MDR, 2 imm-U, 3 PC); cause  out  CAUSE_W.

Function
REQ-011 The block SHALL implement states FETCH=0, DECODE=1, ADDR=2, MEMRD=3, MEMWR=4, LOADWB=5, EXEC=6, ALUWB=7, BRANCH=8, JAL=9, JALR=10, LUI=11, TRAP=12, HALT=13; codes 14-15 go to FETCH next cycle.
REQ-012 In every state, every output not explicitly asserted by that state SHALL be 0 (no held or latched values).
REQ-013 FETCH: mem_req=1, alu_src_a=00, alu_src_b=01, alu_op=add; on the cycle mem_ready=1, ir_load=1 and pc_write=1 (pc_src=00), next=DECODE; otherwise stay in FETCH.
REQ-014 FETCH, first cycle only: if irq=1, mem_req SHALL be 0, next=TRAP with cause=15; irq has priority over the fetch.
REQ-015 A wait counter (8 bits) SHALL clear on entry to FETCH/MEMRD/MEMWR, increment each cycle without mem_ready, and at count==MEM_TIMEOUT force next=TRAP, cause 1 (fetch), 5 (load) or 7 (store).
REQ-016 DECODE: load_a=load_b=load_aluout=1, alu_src_a=00, alu_src_b=11 (branch target precompute); dispatch: OP/OP-IMM/word ops->EXEC, load/store->ADDR, branch->BRANCH, jal->JAL, jalr->JALR, lui->LUI, ecall->TRAP cause 11, ebreak->HALT, anything else->TRAP cause 2.
REQ-017 EXEC: alu_src_a=01, alu_src_b 00 (R) or 10 (I), alu_op from funct3/funct7[5], alu_word set for word ops, load_aluout=1, next=ALUWB; ALUWB: reg_write=1, wb_sel=0, next=FETCH.
REQ-018 ADDR: alu_src_a=01, alu_src_b=10, add, load_aluout=1, next=MEMRD (load) or MEMWR (store); MEMRD/MEMWR: mem_req=1, mem_we=1 for MEMWR only, held until mem_ready; MEMRD then load_mdr=1, next=LOADWB; MEMWR then next=FETCH.
REQ-019 LOADWB: reg_write=1, wb_sel=1, next=FETCH.
REQ-020 BRANCH: alu_src_a=01, alu_src_b=00, alu_op=sub, branch_mode from funct3, pc_src=01, next=FETCH.
REQ-021 JAL: reg_write=1, wb_sel=3, pc_write=1, pc_src=01, next=FETCH; JALR: reg_write=1, wb_sel=3, alu_src_a=01, alu_src_b=10, add, pc_write=1, pc_src=00, next=FETCH; LUI: reg_write=1, wb_sel=2, next=FETCH.
REQ-022 TRAP: epc_write=1, cause_write=1, pc_write=1, pc_src=10, cause valid, lasting exactly one cycle, next=FETCH.
REQ-023 HALT: halted=1, all other outputs 0; exit only by reset.
REQ-024 Latencies with zero wait states SHALL be: R/I-type 4, load 5, store 4, branch/jal/jalr/lui 3 cycles.

Reset
REQ-025 On reset assertion, state=FETCH and wait counter=0 immediately; all outputs 0 while reset is high, including mid-access (mem_req drops asynchronously).
REQ-026 The first rising clk after reset deassertion SHALL begin FETCH first-cycle behaviour (REQ-013, REQ-014).

Verification
REQ-027 Scenario: instr=0x002081B3 (add), mem_ready tied 1 -> states 0,1,6,7,0; reg_write=1 only in state 7.
REQ-028 Scenario: load 0x0000A183, mem_ready pulsed 3 cycles after MEMRD entry -> 3 wait cycles in state 3, then load_mdr=1, then state 5.
REQ-029 Scenario: MEM_TIMEOUT=15, mem_ready=0 in FETCH -> TRAP after 15 cycles, cause=1, epc_write=1 for one cycle.
REQ-030 Scenario: instr=0x0000007F -> DECODE goes to TRAP with cause=2; instr=0x00100073 -> HALT with halted=1 until reset.
REQ-031 Scenario: irq=1 on first FETCH cycle -> mem_req=0, TRAP with cause=15; reset asserted during MEMWR -> mem_req=0 same cycle, state_o=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RISC-V style datapath.
// Sequences fetch, decode, execute, memory access and write-back. It also
// raises traps for interrupts, illegal opcodes, ecall and memory timeouts.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   instr, irq, mem_ready current IR, level interrupt, memory handshake
//   state_o               current FSM state code
//   mem_req/mem_we/mem_size  memory request controls
//   ir_load .. halted     datapath register enables and status strobes
//   pc_src, branch_mode, alu_src_a, alu_src_b, alu_op, wb_sel  mux selects
//   cause                 trap cause, valid only while in TRAP
module multicycle_ctrl #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 15,
  parameter int CAUSE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               irq,
  input  logic               mem_ready,
  output logic [3:0]         state_o,
  output logic               mem_req,
  output logic               mem_we,
  output logic [1:0]         mem_size,
  output logic               ir_load,
  output logic               pc_write,
  output logic               load_a,
  output logic               load_b,
  output logic               load_aluout,
  output logic               load_mdr,
  output logic               reg_write,
  output logic               epc_write,
  output logic               cause_write,
  output logic               alu_word,
  output logic               halted,
  output logic [1:0]         pc_src,
  output logic [2:0]         branch_mode,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_op,
  output logic [2:0]         wb_sel,
  output logic [CAUSE_W-1:0] cause
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_ADDR   = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWR  = 4'd4,  S_LOADWB = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_JAL    = 4'd9,  S_JALR   = 4'd10, S_LUI   = 4'd11,
    S_TRAP   = 4'd12, S_HALT   = 4'd13
  } state_t;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [CAUSE_W-1:0] C_IFETCH  = CAUSE_W'(4'd1);
  localparam logic [CAUSE_W-1:0] C_ILLEGAL = CAUSE_W'(4'd2);
  localparam logic [CAUSE_W-1:0] C_LOAD    = CAUSE_W'(4'd5);
  localparam logic [CAUSE_W-1:0] C_STORE   = CAUSE_W'(4'd7);
  localparam logic [CAUSE_W-1:0] C_ECALL   = CAUSE_W'(4'd11);
  localparam logic [CAUSE_W-1:0] C_IRQ     = CAUSE_W'(4'd15);

  localparam bit WORD_OK = (XLEN == 64);
  // The counter is compared before it increments, so the trap fires on the
  // MEM_TIMEOUT-th consecutive cycle without mem_ready.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t               state_r;
  logic [7:0]           wait_cnt_r;
  logic [CAUSE_W-1:0]   cause_r;

  logic [6:0]           opcode_s;
  logic [2:0]           funct3_s;
  logic                 alt_s;
  logic                 first_irq_s;
  state_t               dec_next_s;
  logic [CAUSE_W-1:0]   dec_cause_s;
  logic [3:0]           exec_op_s;
  logic [2:0]           bmode_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign alt_s    = instr[30];
  // The wait counter is still zero only on the first FETCH cycle.
  assign first_irq_s = (wait_cnt_r == 8'd0) && irq;

  // Opcode dispatch out of DECODE, with the trap cause for rejected encodings.
  always_comb begin
    dec_next_s  = S_TRAP;
    dec_cause_s = C_ILLEGAL;
    case (opcode_s)
      OPC_OP, OPC_OPIMM:     dec_next_s = S_EXEC;
      OPC_OP32, OPC_OPIMM32: begin
        if (WORD_OK) dec_next_s = S_EXEC;
        else         dec_next_s = S_TRAP;
      end
      OPC_LOAD, OPC_STORE:   dec_next_s = S_ADDR;
      OPC_BRANCH:            dec_next_s = S_BRANCH;
      OPC_JAL:               dec_next_s = S_JAL;
      OPC_JALR:              dec_next_s = S_JALR;
      OPC_LUI:               dec_next_s = S_LUI;
      OPC_SYSTEM: begin
        if (instr == INSTR_ECALL) begin
          dec_next_s  = S_TRAP;
          dec_cause_s = C_ECALL;
        end else if (instr == INSTR_EBREAK) begin
          dec_next_s = S_HALT;
        end else begin
          dec_next_s = S_TRAP;
        end
      end
      default:               dec_next_s = S_TRAP;
    endcase
  end

  // ALU operation for EXEC; funct7[5] selects sub only for register forms.
  always_comb begin
    exec_op_s = 4'd0;
    case (funct3_s)
      3'b000:  exec_op_s = (opcode_s[5] && alt_s) ? 4'd1 : 4'd0;
      3'b001:  exec_op_s = 4'd7;
      3'b010:  exec_op_s = 4'd5;
      3'b011:  exec_op_s = 4'd6;
      3'b100:  exec_op_s = 4'd4;
      3'b101:  exec_op_s = alt_s ? 4'd9 : 4'd8;
      3'b110:  exec_op_s = 4'd3;
      3'b111:  exec_op_s = 4'd2;
      default: exec_op_s = 4'd0;
    endcase
  end

  // Branch comparison kind from funct3; reserved encodings compare nothing.
  always_comb begin
    bmode_s = 3'd0;
    case (funct3_s)
      3'b000:  bmode_s = 3'd1;
      3'b001:  bmode_s = 3'd2;
      3'b100:  bmode_s = 3'd3;
      3'b101:  bmode_s = 3'd4;
      3'b110:  bmode_s = 3'd5;
      3'b111:  bmode_s = 3'd6;
      default: bmode_s = 3'd0;
    endcase
  end

  // State, memory wait counter and latched trap cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= 8'd0;
      cause_r    <= '0;
    end else begin
      wait_cnt_r <= 8'd0;
      case (state_r)
        S_FETCH: begin
          if (first_irq_s) begin
            state_r <= S_TRAP;
            cause_r <= C_IRQ;
          end else if (mem_ready) begin
            state_r <= S_DECODE;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r <= S_TRAP;
            cause_r <= C_IFETCH;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_DECODE: begin
          state_r <= dec_next_s;
          cause_r <= dec_cause_s;
        end
        S_ADDR: begin
          if (opcode_s == OPC_STORE) state_r <= S_MEMWR;
          else                       state_r <= S_MEMRD;
        end
        S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            state_r <= (state_r == S_MEMRD) ? S_LOADWB : S_FETCH;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r <= S_TRAP;
            cause_r <= (state_r == S_MEMRD) ? C_LOAD : C_STORE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_EXEC:  state_r <= S_ALUWB;
        S_HALT:  state_r <= S_HALT;
        default: state_r <= S_FETCH;
      endcase
    end
  end

  // Output decode; everything is forced to zero while reset is high.
  always_comb begin
    state_o = 4'd0;  mem_req = 1'b0;  mem_we = 1'b0;  mem_size = 2'b00;
    ir_load = 1'b0;  pc_write = 1'b0; load_a = 1'b0;  load_b = 1'b0;
    load_aluout = 1'b0; load_mdr = 1'b0; reg_write = 1'b0;
    epc_write = 1'b0; cause_write = 1'b0; alu_word = 1'b0; halted = 1'b0;
    pc_src = 2'b00;  branch_mode = 3'd0; alu_src_a = 2'b00; alu_src_b = 2'b00;
    alu_op = 4'd0;   wb_sel = 3'd0;   cause = '0;
    if (!reset) begin
      state_o = state_r;
      case (state_r)
        S_FETCH: begin
          alu_src_b = 2'b01;
          mem_size  = 2'b10;
          if (first_irq_s) begin
            mem_req = 1'b0;
          end else begin
            mem_req  = 1'b1;
            ir_load  = mem_ready;
            pc_write = mem_ready;
          end
        end
        S_DECODE: begin
          load_a = 1'b1; load_b = 1'b1; load_aluout = 1'b1;
          alu_src_b = 2'b11;
        end
        S_ADDR: begin
          alu_src_a = 2'b01; alu_src_b = 2'b10; load_aluout = 1'b1;
        end
        S_MEMRD: begin
          mem_req = 1'b1; mem_size = funct3_s[1:0]; load_mdr = mem_ready;
        end
        S_MEMWR: begin
          mem_req = 1'b1; mem_we = 1'b1; mem_size = funct3_s[1:0];
        end
        S_LOADWB: begin
          reg_write = 1'b1; wb_sel = 3'd1;
        end
        S_EXEC: begin
          alu_src_a   = 2'b01;
          alu_src_b   = opcode_s[5] ? 2'b00 : 2'b10;
          alu_op      = exec_op_s;
          alu_word    = opcode_s[3];
          load_aluout = 1'b1;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 2'b01; alu_op = 4'd1; branch_mode = bmode_s; pc_src = 2'b01;
        end
        S_JAL: begin
          reg_write = 1'b1; wb_sel = 3'd3; pc_write = 1'b1; pc_src = 2'b01;
        end
        S_JALR: begin
          reg_write = 1'b1; wb_sel = 3'd3; alu_src_a = 2'b01; alu_src_b = 2'b10;
          pc_write = 1'b1;
        end
        S_LUI: begin
          reg_write = 1'b1; wb_sel = 3'd2;
        end
        S_TRAP: begin
          epc_write = 1'b1; cause_write = 1'b1; pc_write = 1'b1; pc_src = 2'b10;
          cause = cause_r;
        end
        S_HALT:  halted = 1'b1;
        default: state_o = state_r;
      endcase
    end else begin
      state_o = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each step drives inputs, pushes the
// expected outputs onto a scoreboard and pops/compares them mid-cycle.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset, irq, mem_ready;
  logic [31:0] instr;
  logic [3:0]  state_o, alu_op, cause;
  logic        mem_req, mem_we, ir_load, pc_write, load_a, load_b, load_aluout;
  logic        load_mdr, reg_write, epc_write, cause_write, alu_word, halted;
  logic [1:0]  mem_size, pc_src, alu_src_a, alu_src_b;
  logic [2:0]  branch_mode, wb_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  st;
    logic [12:0] fl;
    logic [17:0] sl;
    logic [3:0]  ca;
  } exp_t;
  exp_t sb[$];

  // Flag bits: {mem_req, mem_we, ir_load, pc_write, load_a, load_b, load_aluout,
  //             load_mdr, reg_write, epc_write, cause_write, alu_word, halted}
  localparam logic [12:0] MR  = 13'h1000, MW  = 13'h0800, IRL = 13'h0400;
  localparam logic [12:0] PCW = 13'h0200, LA  = 13'h0100, LB  = 13'h0080;
  localparam logic [12:0] LAO = 13'h0040, LMD = 13'h0020, RW  = 13'h0010;
  localparam logic [12:0] EPC = 13'h0008, CW  = 13'h0004, AW  = 13'h0002;
  localparam logic [12:0] HLT = 13'h0001, NONE = 13'h0000;

  // Select bits: {alu_src_a, alu_src_b, alu_op, wb_sel, pc_src, branch_mode, mem_size}
  localparam logic [17:0] S_NONE  = 18'd0;
  localparam logic [17:0] S_FETCH = {2'd0, 2'd1, 4'd0, 3'd0, 2'd0, 3'd0, 2'd2};
  localparam logic [17:0] S_DEC   = {2'd0, 2'd3, 4'd0, 3'd0, 2'd0, 3'd0, 2'd0};
  localparam logic [17:0] S_ADDR  = {2'd1, 2'd2, 4'd0, 3'd0, 2'd0, 3'd0, 2'd0};
  localparam logic [17:0] S_MEMW  = {2'd0, 2'd0, 4'd0, 3'd0, 2'd0, 3'd0, 2'd2};
  localparam logic [17:0] S_LDWB  = {2'd0, 2'd0, 4'd0, 3'd1, 2'd0, 3'd0, 2'd0};
  localparam logic [17:0] S_JAL   = {2'd0, 2'd0, 4'd0, 3'd3, 2'd1, 3'd0, 2'd0};
  localparam logic [17:0] S_JALR  = {2'd1, 2'd2, 4'd0, 3'd3, 2'd0, 3'd0, 2'd0};
  localparam logic [17:0] S_LUI   = {2'd0, 2'd0, 4'd0, 3'd2, 2'd0, 3'd0, 2'd0};
  localparam logic [17:0] S_TRAP  = {2'd0, 2'd0, 4'd0, 3'd0, 2'd2, 3'd0, 2'd0};

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .irq(irq), .mem_ready(mem_ready),
    .state_o(state_o), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .ir_load(ir_load), .pc_write(pc_write), .load_a(load_a), .load_b(load_b),
    .load_aluout(load_aluout), .load_mdr(load_mdr), .reg_write(reg_write),
    .epc_write(epc_write), .cause_write(cause_write), .alu_word(alu_word),
    .halted(halted), .pc_src(pc_src), .branch_mode(branch_mode),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .wb_sel(wb_sel), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    exp_t e;
    logic [12:0] fl_o;
    logic [17:0] sl_o;
    e    = sb.pop_front();
    fl_o = {mem_req, mem_we, ir_load, pc_write, load_a, load_b, load_aluout,
            load_mdr, reg_write, epc_write, cause_write, alu_word, halted};
    sl_o = {alu_src_a, alu_src_b, alu_op, wb_sel, pc_src, branch_mode, mem_size};
    total++;
    assert (state_o === e.st) else begin
      bad++; $error("FAIL %s.state got %0d want %0d", tag, state_o, e.st);
    end
    total++;
    assert (fl_o === e.fl) else begin
      bad++; $error("FAIL %s.flags got %h want %h", tag, fl_o, e.fl);
    end
    total++;
    assert (sl_o === e.sl) else begin
      bad++; $error("FAIL %s.selects got %h want %h", tag, sl_o, e.sl);
    end
    total++;
    assert (cause === e.ca) else begin
      bad++; $error("FAIL %s.cause got %0d want %0d", tag, cause, e.ca);
    end
  endtask

  // One clock cycle: drive inputs just after a falling edge, check 1 time unit later.
  task automatic step(input string tag, input logic rst, input logic rdy, input logic irqv,
                      input logic [3:0] st, input logic [12:0] fl,
                      input logic [17:0] sl, input logic [3:0] ca);
    exp_t e;
    reset = rst; mem_ready = rdy; irq = irqv;
    e = '{st, fl, sl, ca};
    sb.push_back(e);
    #1;
    check(tag);
    @(negedge clk);
  endtask

  task automatic fetch_decode(input string tag, input logic [31:0] ins);
    instr = ins;
    step(tag, 1'b0, 1'b1, 1'b0, 4'd0, MR | IRL | PCW, S_FETCH, 4'd0);
    step(tag, 1'b0, 1'b0, 1'b0, 4'd1, LA | LB | LAO, S_DEC, 4'd0);
  endtask

  task automatic run_alu(input string tag, input logic [31:0] ins, input logic [1:0] b,
                         input logic [3:0] op, input logic w);
    fetch_decode(tag, ins);
    step(tag, 1'b0, 1'b1, 1'b0, 4'd6, w ? (LAO | AW) : LAO, {2'd1, b, op, 10'd0}, 4'd0);
    step(tag, 1'b0, 1'b1, 1'b0, 4'd7, RW, S_NONE, 4'd0);
  endtask

  task automatic run_short(input string tag, input logic [31:0] ins, input logic [3:0] st,
                           input logic [12:0] fl, input logic [17:0] sl, input logic [3:0] ca);
    fetch_decode(tag, ins);
    step(tag, 1'b0, 1'b1, 1'b0, st, fl, sl, ca);
  endtask

  initial begin
    reset = 1'b1; irq = 1'b0; mem_ready = 1'b1; instr = 32'h002081B3;
    @(negedge clk);
    step("reset", 1'b1, 1'b1, 1'b0, 4'd0, NONE, S_NONE, 4'd0);
    step("reset_irq", 1'b1, 1'b1, 1'b1, 4'd0, NONE, S_NONE, 4'd0);

    run_alu("add",   32'h002081B3, 2'd0, 4'd0, 1'b0);
    run_alu("subw",  32'h40B5053B, 2'd0, 4'd1, 1'b1);
    run_alu("addi_neg", 32'hFFF00093, 2'd2, 4'd0, 1'b0);
    run_alu("srai",  32'h4010D093, 2'd2, 4'd9, 1'b0);

    // Load with three wait states in MEMRD.
    fetch_decode("lw", 32'h0000A183);
    step("lw", 1'b0, 1'b0, 1'b0, 4'd2, LAO, S_ADDR, 4'd0);
    for (int i = 0; i < 3; i++) step("lw_wait", 1'b0, 1'b0, 1'b0, 4'd3, MR, S_MEMW, 4'd0);
    step("lw_rdy", 1'b0, 1'b1, 1'b0, 4'd3, MR | LMD, S_MEMW, 4'd0);
    step("lw_wb", 1'b0, 1'b0, 1'b0, 4'd5, RW, S_LDWB, 4'd0);

    fetch_decode("sw", 32'h0020A223);
    step("sw", 1'b0, 1'b0, 1'b0, 4'd2, LAO, S_ADDR, 4'd0);
    step("sw_mem", 1'b0, 1'b1, 1'b0, 4'd4, MR | MW, S_MEMW, 4'd0);

    run_short("bne",  32'h00209463, 4'd8, NONE, {2'd1, 2'd0, 4'd1, 3'd0, 2'd1, 3'd2, 2'd0}, 4'd0);
    run_short("bgeu", 32'h0020F463, 4'd8, NONE, {2'd1, 2'd0, 4'd1, 3'd0, 2'd1, 3'd6, 2'd0}, 4'd0);
    run_short("jal",  32'h0000006F, 4'd9,  RW | PCW, S_JAL, 4'd0);
    run_short("jalr", 32'h00008067, 4'd10, RW | PCW, S_JALR, 4'd0);
    run_short("lui",  32'h123450B7, 4'd11, RW, S_LUI, 4'd0);
    run_short("ecall", 32'h00000073, 4'd12, EPC | CW | PCW, S_TRAP, 4'd11);
    run_short("illegal", 32'h0000007F, 4'd12, EPC | CW | PCW, S_TRAP, 4'd2);

    // Fetch timeout: 15 cycles without mem_ready, then a one-cycle trap.
    instr = 32'h002081B3;
    for (int i = 0; i < 15; i++) step("if_wait", 1'b0, 1'b0, 1'b0, 4'd0, MR, S_FETCH, 4'd0);
    step("if_timeout", 1'b0, 1'b0, 1'b0, 4'd12, EPC | CW | PCW, S_TRAP, 4'd1);

    // Load timeout.
    fetch_decode("lw_to", 32'h0000A183);
    step("lw_to", 1'b0, 1'b0, 1'b0, 4'd2, LAO, S_ADDR, 4'd0);
    for (int i = 0; i < 15; i++) step("lw_to_wait", 1'b0, 1'b0, 1'b0, 4'd3, MR, S_MEMW, 4'd0);
    step("lw_timeout", 1'b0, 1'b0, 1'b0, 4'd12, EPC | CW | PCW, S_TRAP, 4'd5);

    // Interrupt on first FETCH cycle wins over a ready fetch.
    step("irq_first", 1'b0, 1'b1, 1'b1, 4'd0, NONE, S_FETCH, 4'd0);
    step("irq_trap", 1'b0, 1'b1, 1'b1, 4'd12, EPC | CW | PCW, S_TRAP, 4'd15);
    // Interrupt after the first FETCH cycle is ignored.
    instr = 32'h123450B7;
    step("irq_late0", 1'b0, 1'b0, 1'b0, 4'd0, MR, S_FETCH, 4'd0);
    step("irq_late1", 1'b0, 1'b0, 1'b1, 4'd0, MR, S_FETCH, 4'd0);
    step("irq_late2", 1'b0, 1'b1, 1'b1, 4'd0, MR | IRL | PCW, S_FETCH, 4'd0);
    step("irq_late3", 1'b0, 1'b0, 1'b0, 4'd1, LA | LB | LAO, S_DEC, 4'd0);
    step("irq_late4", 1'b0, 1'b0, 1'b0, 4'd11, RW, S_LUI, 4'd0);

    // ebreak halts until reset.
    fetch_decode("ebreak", 32'h00100073);
    step("halt0", 1'b0, 1'b1, 1'b1, 4'd13, HLT, S_NONE, 4'd0);
    step("halt1", 1'b0, 1'b0, 1'b0, 4'd13, HLT, S_NONE, 4'd0);
    step("halt2", 1'b0, 1'b1, 1'b0, 4'd13, HLT, S_NONE, 4'd0);
    step("halt_rst", 1'b1, 1'b1, 1'b0, 4'd0, NONE, S_NONE, 4'd0);

    // Reset in the middle of a store drops mem_req at once.
    fetch_decode("sw_rst", 32'h0020A223);
    step("sw_rst", 1'b0, 1'b0, 1'b0, 4'd2, LAO, S_ADDR, 4'd0);
    step("sw_rst_mem", 1'b0, 1'b0, 1'b0, 4'd4, MR | MW, S_MEMW, 4'd0);
    step("sw_rst_hit", 1'b1, 1'b0, 1'b0, 4'd0, NONE, S_NONE, 4'd0);
    step("post_rst", 1'b0, 1'b0, 1'b0, 4'd0, MR, S_FETCH, 4'd0);

    total++;
    assert (sb.size() == 0) else begin
      bad++; $error("FAIL sb_drain got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
